// File: rtl/local_traffic_node.sv
// Local-port traffic endpoint: LFSR-driven flit injector plus a counting sink.
// Define LOCAL_SINK_STALL_EN to build the pseudo-random sink stall on ej_busy.

`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef HDR_SZ
`define HDR_SZ 4
`endif

module local_traffic_node #(
  parameter logic [15:0]         SEED    = 16'hACE1,
  parameter int                  CNT_W   = 16,
  parameter logic [`HDR_SZ-1:0]  HDR_VAL = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [`ADDR_SZ-1:0]                  id,
  input  logic                                 enable,
  input  logic [7:0]                           rate,
  output logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0]   inj_data,
  output logic                                 inj_valid,
  input  logic                                 inj_busy,
  input  logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0]   ej_data,
  input  logic                                 ej_valid,
  output logic                                 ej_busy,
  output logic [CNT_W-1:0]                     sent_count,
  output logic [CNT_W-1:0]                     recv_count,
  output logic [CNT_W-1:0]                     err_count
);

  localparam int AW = `ADDR_SZ;
  localparam int PW = `PL_SZ;
  localparam int HW = `HDR_SZ;
  localparam int FW = HW + PW + AW;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d, lfsr_seed, lfsr_init;
  logic [FW-1:0]   inj_data_q, inj_data_d;
  logic            inj_valid_q, inj_valid_d;
  logic [PW-1:0]   seq_q, seq_d;
  logic [AW-1:0]   dest_raw, dest;
  logic            transfer, consume, addr_err;
  logic [2:0]      cnt_inc;
  logic            unused_ej_hdr;

  // A zero seed would lock the LFSR, so fall back to 1.
  assign lfsr_seed = SEED ^ 16'(id);
  assign lfsr_init = (lfsr_seed == 16'h0000) ? 16'h0001 : lfsr_seed;
  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign dest_raw = lfsr_q[8 +: AW];
  assign dest     = (dest_raw == id) ? id + AW'(1) : dest_raw;

  assign transfer = inj_valid_q && !inj_busy;
  assign consume  = ej_valid && !ej_busy;
  assign addr_err = ej_data[AW-1:0] != id;
  assign cnt_inc  = {consume && addr_err, consume, transfer};
  assign unused_ej_hdr = ^ej_data[FW-1:AW];

  always_comb begin
    state_d     = state_q;
    inj_valid_d = inj_valid_q;
    inj_data_d  = inj_data_q;
    seq_d       = seq_q;
    case (state_q)
      IDLE: begin
        if (enable && (lfsr_q[7:0] < rate)) begin
          state_d     = OFFER;
          inj_valid_d = 1'b1;
          inj_data_d  = {HDR_VAL, seq_q, dest};
        end
      end
      OFFER: begin
        // The offer is never withdrawn, even if enable drops meanwhile.
        if (!inj_busy) begin
          state_d     = IDLE;
          inj_valid_d = 1'b0;
          seq_d       = seq_q + PW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        inj_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      inj_valid_q <= 1'b0;
      inj_data_q  <= '0;
      seq_q       <= '0;
      lfsr_q      <= lfsr_init;
    end else begin
      state_q     <= state_d;
      inj_valid_q <= inj_valid_d;
      inj_data_q  <= inj_data_d;
      seq_q       <= seq_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign inj_valid = inj_valid_q;
  assign inj_data  = inj_data_q;

  // Saturating counters: 0 = sent, 1 = received, 2 = address errors.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;
      always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}}))
          cnt_d = cnt_q + CNT_W'(1);
      end
      always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign sent_count = g_cnt[0].cnt_q;
  assign recv_count = g_cnt[1].cnt_q;
  assign err_count  = g_cnt[2].cnt_q;

`ifdef LOCAL_SINK_STALL_EN
  logic ej_busy_q, ej_busy_d;
  assign ej_busy_d = lfsr_q[15] & lfsr_q[14];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ej_busy_q <= 1'b0;
    else       ej_busy_q <= ej_busy_d;
  end
  assign ej_busy = ej_busy_q;
`else
  assign ej_busy = 1'b0;
`endif

endmodule

// File: tb/tb_local_traffic_node.sv
// Self-checking bench for local_traffic_node: cycle reference model, vector table
// and hand-written corner sequences.

`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef HDR_SZ
`define HDR_SZ 4
`endif

module tb_local_traffic_node;
  localparam int AW = `ADDR_SZ;
  localparam int PW = `PL_SZ;
  localparam int HW = `HDR_SZ;
  localparam int FW = HW + PW + AW;
  localparam logic [15:0]   SEED_TB = 16'hACE1;
  localparam logic [HW-1:0] HDR_TB  = HW'(4'hA);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [AW-1:0] id = '0;
  logic enable = 1'b0;
  logic [7:0] rate = '0;
  logic inj_busy = 1'b0;
  logic [FW-1:0] ej_data = '0;
  logic ej_valid = 1'b0;

  logic [FW-1:0] inj_data, inj_data2;
  logic inj_valid, inj_valid2, ej_busy, ej_busy2;
  logic [15:0] sent, recv, err;
  logic [3:0] sent2, recv2, err2;

  int vectors = 0;
  int miscompares = 0;

  local_traffic_node #(.SEED(SEED_TB), .CNT_W(16), .HDR_VAL(HDR_TB)) dut (
    .clk(clk), .reset(reset), .id(id), .enable(enable), .rate(rate),
    .inj_data(inj_data), .inj_valid(inj_valid), .inj_busy(inj_busy),
    .ej_data(ej_data), .ej_valid(ej_valid), .ej_busy(ej_busy),
    .sent_count(sent), .recv_count(recv), .err_count(err));

  local_traffic_node #(.SEED(SEED_TB), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id(id), .enable(enable), .rate(rate),
    .inj_data(inj_data2), .inj_valid(inj_valid2), .inj_busy(inj_busy),
    .ej_data(ej_data), .ej_valid(ej_valid), .ej_busy(ej_busy2),
    .sent_count(sent2), .recv_count(recv2), .err_count(err2));

  always #5 clk = ~clk;

  // Reference model: pending offer as a queue, plain integer totals.
  logic [FW-1:0] m_pend[$];
  int            m_seq, m_sent, m_recv, m_err;
  logic [15:0]   m_lfsr;
  logic          m_busy;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_pend.delete();
    m_seq = 0; m_sent = 0; m_recv = 0; m_err = 0; m_busy = 1'b0;
    m_lfsr = SEED_TB ^ 16'(id);
    if (m_lfsr == 16'h0000) m_lfsr = 16'h0001;
  endtask

  task automatic model_edge();
    logic [AW-1:0] d;
    if (ej_valid && !m_busy) begin
      m_recv++;
      if (ej_data[AW-1:0] != id) m_err++;
    end
    if (m_pend.size() != 0) begin
      if (!inj_busy) begin
        void'(m_pend.pop_front());
        m_sent++;
        m_seq = (m_seq + 1) % (1 << PW);
      end
    end else if (enable && (int'(m_lfsr[7:0]) < int'(rate))) begin
      d = m_lfsr[8 +: AW];
      if (d == id) d = AW'((int'(id) + 1) % (1 << AW));
      m_pend.push_back({HDR_TB, PW'(m_seq), d});
    end
`ifdef LOCAL_SINK_STALL_EN
    m_busy = m_lfsr[15] & m_lfsr[14];
`else
    m_busy = 1'b0;
`endif
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("inj_valid", 32'(inj_valid), 32'(m_pend.size() != 0));
    chk("inj_valid2", 32'(inj_valid2), 32'(m_pend.size() != 0));
    if (m_pend.size() != 0) begin
      chk("inj_data", 32'(inj_data), 32'(m_pend[0]));
      chk("inj_data2", 32'(inj_data2[PW+AW-1:0]), 32'(m_pend[0][PW+AW-1:0]));
    end
    if (inj_valid) chk("dest_ne_id", 32'(inj_data[AW-1:0] != id), 32'd1);
    chk("sent", 32'(sent), 32'(sat(m_sent, 65535)));
    chk("recv", 32'(recv), 32'(sat(m_recv, 65535)));
    chk("err", 32'(err), 32'(sat(m_err, 65535)));
    chk("sent2", 32'(sent2), 32'(sat(m_sent, 15)));
    chk("recv2", 32'(recv2), 32'(sat(m_recv, 15)));
    chk("err2", 32'(err2), 32'(sat(m_err, 15)));
    chk("ej_busy", 32'(ej_busy), 32'(m_busy));
    chk("ej_busy2", 32'(ej_busy2), 32'(m_busy));
  endtask

  // One clock: model updates on the edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Called at a falling edge; reset must take effect without a clock edge.
  task automatic do_reset(input logic [AW-1:0] new_id);
    id = new_id;
    #1 reset = 1'b1;
    #1;
    model_reset();
    chk("rst_inj_valid", 32'(inj_valid), 32'd0);
    chk("rst_inj_data", 32'(inj_data), 32'd0);
    chk("rst_counts", 32'({sent, recv, err} != '0), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (inj_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("wait_valid", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    int            err_inc;
  } ej_vec_t;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    ej_vec_t tbl[7];
    logic [FW-1:0] held;
    int s0, r0, e0, exp_c;

    tbl[0] = '{AW'(5), 0};
    tbl[1] = '{AW'(5), 0};
    tbl[2] = '{AW'(5), 0};
    tbl[3] = '{AW'(6), 1};
    tbl[4] = '{AW'(4), 1};
    tbl[5] = '{AW'(15), 1};
    tbl[6] = '{AW'(5), 0};

    @(negedge clk);
    do_reset(AW'(0));

    // Idle: nothing injected, nothing counted.
    for (int i = 0; i < 100; i++) step();
    chk("idle_valid", 32'(inj_valid), 32'd0);
    chk("idle_counts", 32'({sent, recv, err} != '0), 32'd0);

    // Full-rate injection from reset.
    do_reset(AW'(3));
    enable = 1'b1; rate = 8'd255; inj_busy = 1'b0;
    for (int i = 0; i < 64; i++) step();
    chk("rate255_min", 32'(sent >= 16'd29), 32'd1);
    chk("rate255_max", 32'(sent <= 16'd32), 32'd1);

    // Back-pressure: held for 5 busy cycles, enable dropped before release.
    inj_busy = 1'b1;
    wait_valid();
    held = inj_data; s0 = int'(sent);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) enable = 1'b0;
      step();
      chk("busy_stable", 32'(inj_data), 32'(held));
      chk("busy_valid", 32'(inj_valid), 32'd1);
    end
    inj_busy = 1'b0;
    step();
    chk("busy_sent_once", 32'(sent), 32'(s0 + 1));
    chk("busy_gap", 32'(inj_valid), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("disabled_no_more", 32'(sent), 32'(s0 + 1));
    enable = 1'b1;
    wait_valid();
    chk("seq_advanced", 32'(inj_data[AW +: PW]), 32'((int'(held[AW +: PW]) + 1) % (1 << PW)));

    // Sink table, id=5.
    enable = 1'b0;
    do_reset(AW'(5));
    for (int k = 0; k < 7; k++) begin
      r0 = int'(recv); e0 = int'(err);
      exp_c = m_busy ? 0 : 1;
      ej_valid = 1'b1;
      ej_data = {HW'($urandom), PW'($urandom), tbl[k].addr};
      step();
      ej_valid = 1'b0;
      chk("tbl_recv", 32'(int'(recv) - r0), 32'(exp_c));
      chk("tbl_err", 32'(int'(err) - e0), 32'(exp_c * tbl[k].err_inc));
`ifndef LOCAL_SINK_STALL_EN
      if (k == 3) begin
        chk("sink_recv4", 32'(recv), 32'd4);
        chk("sink_err1", 32'(err), 32'd1);
      end
`endif
    end

    // Reset in the middle of an offer drops the flit.
    enable = 1'b1; rate = 8'd255; inj_busy = 1'b1;
    wait_valid();
    do_reset(AW'(5));
    inj_busy = 1'b0;
    wait_valid();
    chk("first_payload", 32'(inj_data[AW +: PW]), 32'd0);

    // Randomised traffic in segments of varying rate.
    for (int seg = 0; seg < 20; seg++) begin
      case ($urandom_range(0, 3))
        0: rate = 8'd0;
        1: rate = 8'd255;
        default: rate = 8'($urandom);
      endcase
      if ($urandom_range(0, 4) == 0) do_reset(AW'($urandom));
      for (int i = 0; i < 80; i++) begin
        enable   = ($urandom_range(0, 3) != 0);
        inj_busy = ($urandom_range(0, 2) == 0);
        ej_valid = $urandom_range(0, 1);
        ej_data  = FW'($urandom);
        if ($urandom_range(0, 1) == 1) ej_data[AW-1:0] = id;
        step();
      end
    end

    // Saturation of the narrow counters.
    enable = 1'b0; inj_busy = 1'b0;
    do_reset(AW'(9));
    ej_valid = 1'b1;
    ej_data = {HW'(0), PW'(0), AW'(9)};
    for (int i = 0; i < 200 && m_recv < 20; i++) step();
    ej_valid = 1'b0;
    chk("sat_reached", 32'(m_recv >= 20), 32'd1);
    chk("sat_recv2", 32'(recv2), 32'd15);
    chk("sat_recv16", 32'(recv), 32'(m_recv));
    step();
    chk("sat_hold", 32'(recv2), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/local_traffic_node.md
Name: local_traffic_node

Overview:
Traffic endpoint attached to a router's parallel local port. Upstream of the router it injects pseudo-random flits addressed to other nodes. Downstream of it, it consumes flits the router ejects locally. Each received flit's destination is checked against the node id, and sent, received and error totals are counted for mesh-level throughput and correctness runs.

Parameters:
SEED, 16'hACE1, LFSR seed; it is XORed with the zero-extended id at reset.
CNT_W, 16, width of the sent, received and error counters.
HDR_VAL, 0, constant header field placed in every injected flit (`HDR_SZ bits).

Ports:
clk  in  1  local clock, the same clock as the attached router.
reset  in  1  asynchronous, active-high.
id  in  `ADDR_SZ  address of this node.
enable  in  1  injection enable; the sink side is always active.
rate  in  8  injection threshold; a flit is generated when lfsr[7:0] < rate.
inj_data  out  `HDR_SZ+`PL_SZ+`ADDR_SZ  flit to the router's local input.
inj_valid  out  1  flit offered to the router.
inj_busy  in  1  the router's local receive-full flag.
ej_data  in  `HDR_SZ+`PL_SZ+`ADDR_SZ  flit from the router's local output.
ej_valid  in  1  router local-output enable.
ej_busy  out  1  sink stall, driven to the router's local tx busy.
sent_count  out  CNT_W  flits accepted by the router.
recv_count  out  CNT_W  flits consumed.
err_count  out  CNT_W  consumed flits whose address field != id.

Behaviour:
- Flit layout, MSB to LSB: {hdr[`HDR_SZ], payload[`PL_SZ], dest[`ADDR_SZ]}. The payload carries the sequence number seq[`PL_SZ-1:0].
- LFSR: 16-bit Fibonacci register with taps 16, 14, 13, 11. It advances every clock cycle.
  - Reset value is SEED ^ id.
  - If that value is 0, the register loads 16'h0001 instead.
- Injection FSM has two states, IDLE and OFFER.
  - IDLE: if enable && lfsr[7:0] < rate, latch a flit into inj_data and go to OFFER. The flit is dest = lfsr[8+`ADDR_SZ-1:8] and payload = seq.
  - IDLE self-avoidance: if the chosen dest equals id, dest becomes id+1 instead (this wraps modulo 2^`ADDR_SZ).
  - OFFER: inj_valid = 1 and inj_data is held stable.
  - Transfer condition: a rising edge where inj_valid && !inj_busy. On that edge: sent_count+1, seq+1 (wrapping), go to IDLE.
- Gap and rate boundaries:
  - inj_valid drops for at least one cycle between flits, so one flit is sent per transfer.
  - rate = 0 means no injection.
  - rate = 255 injects whenever lfsr[7:0] != 255.
- Deasserting enable while in OFFER does not withdraw the flit. It completes, and the FSM then stays in IDLE.
- Sink: a flit is consumed on a rising edge with ej_valid && !ej_busy.
  - On consume: recv_count+1.
  - Also on consume: if ej_data[`ADDR_SZ-1:0] != id, err_count+1.
  - The sink keeps no buffer; consumption is counted only.
- Simultaneous inject-transfer and eject-consume in the same cycle are independent; both counters update.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset (any time, including mid-OFFER): the following clear asynchronously and immediately:
  - state=IDLE, inj_valid=0, inj_data=0, ej_busy=0
  - seq=0, all counters=0, LFSR=seed
  - A flit in OFFER is dropped and not counted.

Optional Feature:
Macro: LOCAL_SINK_STALL_EN.
- Defined: ej_busy is registered. Each cycle it loads lfsr[15] & lfsr[14], giving roughly a 25% stall rate, to exercise router back-pressure on the local output. Reset value is 0.
- Not defined: ej_busy is constant 0 and no stall logic is built.

Test Plan:
- Reset, then enable=0 and ej_valid=0 for 100 cycles -> inj_valid stays 0 and all counters stay 0.
- id=3, rate=255, inj_busy=0 for 64 cycles -> sent_count is between 29 and 32. No flit has dest=3. Payloads are 0,1,2,... with no gaps.
- Flit offered, inj_busy=1 for 5 cycles then 0 -> inj_data is stable all 6 cycles, sent_count+1 exactly once, seq advances by 1.
- id=5. Drive ej_valid with addr 5 for 3 cycles, then addr 6 for 1 cycle -> recv_count=4, err_count=1.
- Assert reset for 1 cycle mid-OFFER -> inj_valid is 0 at once and all counters are 0. After release with rate=255, the first payload is 0.
- CNT_W=4 with 20 good ejections -> recv_count=15 and holds (saturation). With LOCAL_SINK_STALL_EN defined, no flit is counted in a cycle where ej_busy=1.
